dff_pipe_elastic: RTL and testbench
===================================

Name: dff_pipe_elastic

Overview:
- Parametrised successor to the single D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline.
- Each stage holds data plus a valid bit. A valid/ready handshake provides backpressure.
- Stages are bubble-collapsing: an empty stage always accepts, even while the output is stalled.
- Used wherever a datapath needs N cycles of registered delay with flow control, flush and occupancy visibility.

Parameters:
- WIDTH, 8: data width in bits; legal range >= 1.
- DEPTH, 3: number of register stages; legal range >= 1.
- RESET_VAL, 0: value loaded into every data register on reset. Only the low WIDTH bits are used.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. rst=0 resets immediately; release is synchronised externally.
- in_valid  input  1  upstream data valid.
- in_data  input  WIDTH  upstream data.
- in_ready  output  1  pipeline can accept in_data this cycle.
- out_valid  output  1  valid bit of stage DEPTH-1.
- out_data  output  WIDTH  data register of stage DEPTH-1.
- out_ready  input  1  downstream accepts out_data this cycle.
- flush  input  1  synchronous clear of all valid bits.
- occupancy  output  $clog2(DEPTH+1)  count of stages with valid=1, registered.

Behaviour:
- State per stage i (0..DEPTH-1): data_r[i] (WIDTH bits) and vld_r[i].
- Reset (rst=0, asynchronous):
  - all vld_r=0 and all data_r=RESET_VAL;
  - occupancy=0, out_valid=0, out_data=RESET_VAL;
  - in_ready=1 as soon as rst=1 and flush=0.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready;
  - rdy[i] = !vld_r[i] | rdy[i+1];
  - in_ready = rdy[0] & !flush.
- Stage update on the clk edge when flush=0:
  - If rdy[i]=1: vld_r[i] <= upstream valid (in_valid for i=0, vld_r[i-1] otherwise).
  - If rdy[i]=1 and upstream valid=1: data_r[i] <= upstream data.
  - If rdy[i]=0: the stage holds both data and valid.
  - Data registers are never written with invalid data. On a bubble they keep their old value.
- Handshakes:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_data must be held stable while in_valid=1 and in_ready=0. Violations are not checked.
- Latency: with out_ready held at 1, an accepted word appears on out_data/out_valid exactly DEPTH clock edges after acceptance. Throughput is 1 word/cycle.
- Stall: if out_ready=0, the pipe fills from the tail. in_ready stays 1 until all DEPTH stages are valid. With DEPTH valid words and out_ready=0, in_ready=0.
- Full and draining: out_ready=1 with all stages full means in_ready=1 the same cycle, so accept and drain happen simultaneously.
- Flush:
  - On the clk edge with flush=1, all vld_r <= 0 and occupancy <= 0. Data registers hold.
  - in_valid is ignored that cycle (in_ready=0), so no word is accepted.
  - out_valid remains as registered during the flush cycle. If out_ready=1, the downstream may consume it; this is legal and the word is counted as delivered.
- Occupancy:
  - next = current + (input transfer) - (output transfer), clamped to 0..DEPTH by construction.
  - Registered, so it updates on the same edge as the valid bits.
  - Reset and flush force 0.
  - Must always equal popcount(vld_r). The bench asserts this.
- DEPTH=1: a single registered stage with in_ready = !out_valid | out_ready. Occupancy width is 1.
- Reset mid-operation: all in-flight words are discarded immediately and asynchronously. No partial word emerges after release.

Test Plan:
- Stream, WIDTH=8, DEPTH=3, out_ready=1: send 0x11, 0x22, 0x33 on consecutive cycles → out_valid rises 3 edges after 0x11 is accepted; out_data = 0x11, 0x22, 0x33 on consecutive cycles; occupancy peaks at 3.
- Backpressure with out_ready=0: send 0xA1..0xA4 → 0xA1..0xA3 accepted; in_ready=0 with 0xA4 held; occupancy=3. Raise out_ready → 0xA1 delivered and 0xA4 accepted the same edge; order preserved.
- Bubble collapse: send 0x01, idle 2 cycles, send 0x02, with out_ready=0 → both words end in adjacent tail stages, occupancy=2, in_ready=1.
- Flush: fill with 0x5A, 0x5B, 0x5C, then pulse flush=1 with in_valid=1, in_data=0xFF → next edge occupancy=0, out_valid=0; 0xFF never appears at the output; in_ready=0 during the flush cycle.
- Async reset: drop rst to 0 mid-stream between clock edges → out_valid=0, out_data=RESET_VAL and occupancy=0 immediately, without waiting for a clk edge. After release, the first new word appears after DEPTH edges.
- DEPTH=1, WIDTH=16: alternate out_ready 1/0 with continuous in_valid → in_ready equals !out_valid | out_ready every cycle; no word is lost or duplicated.

Source files
------------

// File: rtl/dff_pipe_elastic.sv
// Elastic WIDTH-bit, DEPTH-stage register pipeline with valid/ready flow control,
// bubble collapsing, synchronous flush and a registered occupancy count.
module dff_pipe_elastic #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 3,
    parameter int RESET_VAL = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int               OCC_W    = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] RST_DATA = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH-1:0] vld_r;
    logic [OCC_W-1:0] occ_r;

    logic [DEPTH:0]   rdy_s;
    logic             room_s;
    logic [DEPTH-1:0] up_vld_s;
    logic [WIDTH-1:0] up_data_s [DEPTH];
    logic             in_xfer_s;
    logic             out_xfer_s;

    // Ready chain: a stage may load when it or any stage downstream of it has room.
    always_comb begin
        rdy_s        = '0;
        room_s       = out_ready;
        rdy_s[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            room_s   = room_s | ~vld_r[i];
            rdy_s[i] = room_s;
        end
    end

    // Upstream source of each stage: the input port for stage 0, the previous stage otherwise.
    always_comb begin
        up_vld_s     = '0;
        up_vld_s[0]  = in_valid;
        up_data_s[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_vld_s[i]  = vld_r[i-1];
            up_data_s[i] = data_r[i-1];
        end
    end

    // Handshake strobes; a flush cycle never accepts new input.
    always_comb begin
        in_ready   = rdy_s[0] & ~flush;
        in_xfer_s  = in_valid & in_ready;
        out_xfer_s = vld_r[DEPTH-1] & out_ready;
    end

    // Valid bits and occupancy; flush drops every valid bit but leaves the data alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_r <= '0;
            occ_r <= '0;
        end else if (flush) begin
            vld_r <= '0;
            occ_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy_s[i]) begin
                    vld_r[i] <= up_vld_s[i];
                end
            end
            occ_r <= occ_r + OCC_W'(in_xfer_s) - OCC_W'(out_xfer_s);
        end
    end

    // Data registers only load real words, so a bubble leaves the old value in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= RST_DATA;
            end
        end else if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy_s[i] && up_vld_s[i]) begin
                    data_r[i] <= up_data_s[i];
                end
            end
        end
    end

    assign out_valid = vld_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];
    assign occupancy = occ_r;

endmodule

// File: tb/tb_dff_pipe_elastic.sv
// Directed bench for dff_pipe_elastic: a DEPTH=3/WIDTH=8 pipe and a DEPTH=1/WIDTH=16 pipe
// sharing clock and reset.
module tb_dff_pipe_elastic;
    logic        clk;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [7:0]  a_in_data, a_out_data;
    logic [1:0]  a_occ;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [15:0] b_in_data, b_out_data;
    logic [0:0]  b_occ;

    int checks;
    int failures;

    dff_pipe_elastic #(.WIDTH(8), .DEPTH(3), .RESET_VAL(0)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .flush(a_flush), .occupancy(a_occ)
    );

    dff_pipe_elastic #(.WIDTH(16), .DEPTH(1), .RESET_VAL(0)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .flush(b_flush), .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        exp_vld;
        logic        exp_rdy;
        logic        in_x;
        logic        out_x;
        logic [15:0] tx_data;
        logic [15:0] rx_next;
        int          rx_count;

        checks = 0;
        failures = 0;
        rst = 1'b0;
        a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1; a_flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = 16'h0000; b_out_ready = 1'b0; b_flush = 1'b0;

        // Reset state
        #3;
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_out_data", a_out_data, 8'h00);
        check("rst_occ", a_occ, 2'd0);
        check("rst_b_out_valid", b_out_valid, 1'b0);
        #9 rst = 1'b1;
        tick();

        // Stream with out_ready=1
        a_in_valid = 1'b1; a_in_data = 8'h11;
        #1 check("str_in_ready", a_in_ready, 1'b1);
        tick();
        a_in_data = 8'h22;
        tick();
        check("str_out_valid_early", a_out_valid, 1'b0);
        a_in_data = 8'h33;
        tick();
        a_in_valid = 1'b0;
        check("str_out_valid", a_out_valid, 1'b1);
        check("str_data0", a_out_data, 8'h11);
        check("str_occ_peak", a_occ, 2'd3);
        tick();
        check("str_data1", a_out_data, 8'h22);
        check("str_occ2", a_occ, 2'd2);
        tick();
        check("str_data2", a_out_data, 8'h33);
        check("str_occ1", a_occ, 2'd1);
        tick();
        check("str_empty", a_out_valid, 1'b0);
        check("str_occ0", a_occ, 2'd0);

        // Backpressure
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'hA1;
        tick();
        a_in_data = 8'hA2;
        tick();
        a_in_data = 8'hA3;
        tick();
        a_in_data = 8'hA4;
        #1;
        check("bp_in_ready_full", a_in_ready, 1'b0);
        check("bp_occ_full", a_occ, 2'd3);
        check("bp_head", a_out_data, 8'hA1);
        tick();
        check("bp_hold_occ", a_occ, 2'd3);
        check("bp_hold_head", a_out_data, 8'hA1);
        check("bp_hold_ready", a_in_ready, 1'b0);
        a_out_ready = 1'b1;
        #1 check("bp_drain_ready", a_in_ready, 1'b1);
        tick();
        a_in_valid = 1'b0;
        check("bp_order_a2", a_out_data, 8'hA2);
        check("bp_occ_same", a_occ, 2'd3);
        tick();
        check("bp_order_a3", a_out_data, 8'hA3);
        tick();
        check("bp_order_a4", a_out_data, 8'hA4);
        check("bp_occ1", a_occ, 2'd1);
        tick();
        check("bp_empty", a_out_valid, 1'b0);

        // Bubble collapse under stall
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h01;
        tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        a_in_valid = 1'b1; a_in_data = 8'h02;
        tick();
        a_in_valid = 1'b0;
        tick();
        #1;
        check("bub_head", a_out_data, 8'h01);
        check("bub_occ", a_occ, 2'd2);
        check("bub_in_ready", a_in_ready, 1'b1);
        a_out_ready = 1'b1;
        tick();
        check("bub_second", a_out_data, 8'h02);
        check("bub_second_vld", a_out_valid, 1'b1);
        tick();
        check("bub_empty", a_out_valid, 1'b0);
        check("bub_occ0", a_occ, 2'd0);

        // Flush with a word offered at the input
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h5A;
        tick();
        a_in_data = 8'h5B;
        tick();
        a_in_data = 8'h5C;
        tick();
        a_flush = 1'b1; a_in_data = 8'hFF;
        #1;
        check("fl_in_ready", a_in_ready, 1'b0);
        check("fl_out_valid_kept", a_out_valid, 1'b1);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("fl_occ", a_occ, 2'd0);
        check("fl_out_valid", a_out_valid, 1'b0);
        check("fl_data_hold", a_out_data, 8'h5A);
        a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fl_no_ff", a_out_valid, 1'b0);
        end

        // Asynchronous reset mid-stream
        a_in_valid = 1'b1; a_in_data = 8'h77;
        tick();
        a_in_data = 8'h88;
        tick();
        a_in_data = 8'h99;
        tick();
        a_in_valid = 1'b0;
        check("ar_pre_valid", a_out_valid, 1'b1);
        check("ar_pre_data", a_out_data, 8'h77);
        #3 rst = 1'b0;
        #1;
        check("ar_out_valid", a_out_valid, 1'b0);
        check("ar_out_data", a_out_data, 8'h00);
        check("ar_occ", a_occ, 2'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        check("ar_post_valid", a_out_valid, 1'b0);
        a_in_valid = 1'b1; a_in_data = 8'hC3;
        tick();
        a_in_valid = 1'b0;
        check("ar_lat_e1", a_out_valid, 1'b0);
        tick();
        check("ar_lat_e2", a_out_valid, 1'b0);
        tick();
        check("ar_lat_e3", a_out_valid, 1'b1);
        check("ar_lat_data", a_out_data, 8'hC3);
        tick();
        check("ar_drained", a_out_valid, 1'b0);

        // DEPTH=1, alternating out_ready with continuous in_valid
        exp_vld = 1'b0;
        tx_data = 16'h1000;
        rx_next = 16'h1000;
        rx_count = 0;
        for (int c = 0; c < 12; c++) begin
            b_out_ready = (c % 2 == 0) ? 1'b1 : 1'b0;
            b_in_valid = 1'b1;
            b_in_data = tx_data;
            #1;
            exp_rdy = ~exp_vld | b_out_ready;
            check("d1_in_ready", b_in_ready, exp_rdy);
            check("d1_out_valid", b_out_valid, exp_vld);
            check("d1_occ", b_occ, exp_vld);
            out_x = exp_vld & b_out_ready;
            in_x = exp_rdy;
            if (out_x) begin
                check("d1_out_data", b_out_data, rx_next);
                rx_next = rx_next + 16'd1;
                rx_count++;
            end
            tick();
            if (in_x) begin
                exp_vld = 1'b1;
                tx_data = tx_data + 16'd1;
            end else if (out_x) begin
                exp_vld = 1'b0;
            end
        end
        b_in_valid = 1'b0;
        check("d1_rx_count", rx_count, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
